// File: rtl/lsu_mem_port_if.sv
// rtl/lsu_mem_port_if.sv - request/response and data-memory port bundle for lsu_mem_port
interface lsu_mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_cen;
  logic [31:0] mem_data;

  // Core pipeline and memory model side
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, mem_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wmask, mem_wdata, mem_cen
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, mem_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wmask, mem_wdata, mem_cen
  );
endinterface

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store initiator driving one synchronous data-memory port
module lsu_mem_port #(
  parameter int ADDR_BITS = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  lsu_mem_port_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_wmask;
  logic [31:0] r_mem_wdata;
  logic        r_mem_cen;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;

  logic        w_err;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_ld_data;

  // Classify the incoming request and build its lane mask and replicated data
  always_comb begin
    w_err = ((bus.req_addr >> ADDR_BITS) != 32'd0);
    w_wmask = 4'b1111;
    w_wdata = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        w_wmask = 4'b0001 << bus.req_addr[1:0];
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_err   = w_err | bus.req_addr[0];
        w_wmask = 4'b0011 << bus.req_addr[1:0];
        w_wdata = {2{bus.req_wdata[15:0]}};
      end
      2'b10: w_err = w_err | (bus.req_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
  end

  // Right-justify the returned word and extend it to 32 bits
  always_comb begin
    w_shift = bus.mem_data >> {r_off, 3'b000};
    case (r_size)
      2'b00:   w_ld_data = r_uns ? {24'd0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_ld_data = r_uns ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ld_data = w_shift;
    endcase
  end

  // Request sequencer; every output is a register so reset drops the strobes at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wmask <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_mem_cen   <= 1'b0;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_off       <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_size      <= bus.req_size;
            r_uns       <= bus.req_unsigned;
            r_off       <= bus.req_addr[1:0];
            r_req_ready <= 1'b0;
            if (w_err) begin
              // Faulting requests skip the memory entirely
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'd0;
            end else begin
              r_state    <= S_ISSUE;
              r_mem_cen  <= 1'b1;
              r_mem_addr <= {bus.req_addr[31:2], 2'b00};
              if (bus.req_we) begin
                r_mem_wmask <= w_wmask;
                r_mem_wdata <= w_wdata;
              end else begin
                r_mem_wmask <= 4'd0;
              end
            end
          end
        end
        S_ISSUE: begin
          r_mem_cen   <= 1'b0;
          r_mem_wmask <= 4'd0;
          if (r_we) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Memory data is valid in this cycle, one after the access strobe
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= w_ld_data;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wmask = r_mem_wmask;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_cen   = r_mem_cen;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - self-checking bench for lsu_mem_port
module tb_lsu_mem_port;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  logic [31:0] mem_w [0:16383];
  logic [7:0]  ref_mem [0:65535];

  lsu_mem_port_if bus();

  lsu_mem_port #(.ADDR_BITS(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Synchronous RAM with registered read port
  always @(posedge clk) begin
    if (bus.mem_cen) begin
      bus.mem_data <= mem_w[bus.mem_addr[15:2]];
      for (int j = 0; j < 4; j++)
        if (bus.mem_wmask[j]) mem_w[bus.mem_addr[15:2]][8*j +: 8] <= bus.mem_wdata[8*j +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and check it end to end against the byte-level model
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rdata);
    logic        exp_err;
    int          nb;
    int          exp_lat;
    int          base;
    int          lat;
    int          ncen;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic [31:0] v;

    exp_err = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'h0001_0000);
    nb   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    base = int'(addr[15:0]);
    exp_mask = 4'd0;
    if (!exp_err)
      for (int i = 0; i < nb; i++) exp_mask[(base % 4) + i] = 1'b1;
    for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wdata[8*(j % nb) +: 8];
    exp_rd = 32'd0;
    if (!exp_err && !we) begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
      if (!uns && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      exp_rd = v;
    end
    exp_lat = exp_err ? 1 : (we ? 2 : 3);

    @(negedge clk);
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.rsp_ready    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Anything on the request bus from here on must be ignored
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0000_0000;
    bus.req_wdata = $urandom;
    bus.req_valid = 1'b1;

    lat  = 0;
    ncen = 0;
    for (int k = 1; k <= 6; k++) begin
      if (bus.mem_cen || bus.mem_wmask != 4'd0) begin
        ncen++;
        chk("mem_cen_on", {31'd0, bus.mem_cen}, 32'd1);
        chk("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
        chk("mem_wmask", {28'd0, bus.mem_wmask}, we ? {28'd0, exp_mask} : 32'd0);
        if (we) chk("mem_wdata", bus.mem_wdata, exp_wd);
      end
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk("latency", lat, exp_lat);
    chk("access_count", ncen, exp_err ? 0 : 1);
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    rdata = bus.rsp_rdata;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("hold_cen", {31'd0, bus.mem_cen}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk("post_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("post_req_ready", {31'd0, bus.req_ready}, 32'd1);

    if (we && !exp_err)
      for (int i = 0; i < nb; i++) ref_mem[base + i] = wdata[8*i +: 8];
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] snap;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;

    n_chk = 0;
    n_err = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.rsp_ready    = 1'b0;
    bus.mem_data     = 32'd0;
    for (int w = 0; w < 16384; w++) begin
      mem_w[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = mem_w[w][8*b +: 8];
    end

    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wmask", {28'd0, bus.mem_wmask}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_cen", {31'd0, bus.mem_cen}, 32'd0);
    rst_n = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd);
    chk("tp_word_load", rd, 32'hDEADBEEF);
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005A, 0, rd);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, rd);
    chk("tp_byte_store_back", rd, 32'h0000005A);
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80123456, 0, rd);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, rd);
    chk("tp_byte_signed", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, rd);
    chk("tp_byte_unsigned", rd, 32'h00000080);
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h9ABC1234, 0, rd);
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 0, rd);
    chk("tp_half_signed", rd, 32'hFFFF9ABC);
    do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 0, rd);
    chk("tp_half_low", rd, 32'h00001234);
    do_req(1'b1, 2'b10, 1'b0, 32'h06, 32'h11111111, 0, rd);
    do_req(1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 0, rd);
    do_req(1'b1, 2'b11, 1'b0, 32'h04, 32'h22222222, 0, rd);
    do_req(1'b1, 2'b10, 1'b0, 32'h0001_0000, 32'h33333333, 0, rd);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, rd);
    chk("tp_backpressure", rd, 32'h80123456);

    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(16, 31));
      do_req(we, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), rd);
    end

    // Reset asserted asynchronously in the middle of a store's access cycle
    snap = mem_w[17];
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h44;
    bus.req_wdata = ~snap;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    chk("rst_mid_cen_before", {31'd0, bus.mem_cen}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cen", {31'd0, bus.mem_cen}, 32'd0);
    chk("rst_mid_wmask", {28'd0, bus.mem_wmask}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_no_write", mem_w[17], snap);
    @(negedge clk);
    chk("rst_rel_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rel_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 0, rd);
    chk("rst_old_data", rd, snap);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator that drives one synchronous data-memory port (a_mem_* or b_mem_* side of the dual-port data RAM) on behalf of a core pipeline.
- Accepts byte/half/word load and store requests over a valid/ready handshake and issues a single memory access per request.
- Produces byte-lane write masks and replicated write data; aligns and sign/zero-extends read data.
- Returns a response with a misalignment/range error flag; erroneous requests never touch memory.

Parameters:
- ADDR_BITS, 16, width of the byte-address window; memory word index is addr[ADDR_BITS-1:2].

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  aligned, extended load data; 0 for stores and errors
- rsp_err  out  1  request was misaligned, illegal size, or out of window
- mem_addr  out  32  byte address to memory, low 2 bits forced 0
- mem_wmask  out  4  byte write enables
- mem_wdata  out  32  lane-replicated store data
- mem_cen  out  1  memory clock-enable / access strobe
- mem_data  in  32  memory read data, valid one cycle after the access cycle

Behaviour:
- Reset (asynchronous, active-low): state IDLE.
  - req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_addr=0, mem_wmask=0, mem_wdata=0, mem_cen=0.
  - Assertion mid-operation aborts immediately: cen/wmask drop in the same instant and no partial write completes after reset.
- All outputs are registered.
- States:
  - IDLE
    - req_ready=1.
    - On req_valid: latch the request.
    - If error: go to RESP with rsp_err=1.
    - Otherwise: go to ISSUE.
  - ISSUE (one cycle): mem_cen=1, mem_addr={req_addr[31:2],2'b00}.
    - Store: mem_wmask per size; next state RESP.
    - Load: mem_wmask=0; next state WAIT.
  - WAIT (one cycle): mem_cen=0, mem_wmask=0.
    - At end of cycle, capture mem_data >> (8*addr[1:0]).
    - Extend from bit 7 (byte) or bit 15 (half) unless req_unsigned.
    - Word: passthrough.
    - Go to RESP.
  - RESP:
    - rsp_valid=1; rsp_rdata/rsp_err stable.
    - Hold until rsp_ready; go to IDLE the cycle after the handshake.
    - req_ready=0 throughout.
- Error conditions:
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr[31:ADDR_BITS] != 0.
- Latency from accept cycle T:
  - Error: rsp_valid at T+1.
  - Store: rsp_valid at T+2.
  - Load: rsp_valid at T+3.
  - Maximum throughput: one request per 3 cycles (store) or 4 cycles (load).
- mem_cen and a nonzero mem_wmask are asserted for exactly one cycle per legal request and never otherwise.
- mem_wmask:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- mem_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- mem_addr and mem_wdata hold their last value outside ISSUE.
- Inputs req_* are ignored outside IDLE.
- rsp_ready is ignored outside RESP.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x0000_0010.
  - ISSUE cycle shows mem_addr 0x10, wmask 1111, cen 1.
  - Load of 0x10 returns rsp_rdata 0xDEADBEEF at T+3, rsp_err 0.
- Byte store 0x5A at 0x0000_0013:
  - wmask 1000, mem_wdata 0x5A5A5A5A.
  - A following signed byte load at 0x13 with mem_data 0x80xxxxxx returns 0xFFFFFF80; unsigned returns 0x00000080.
- Half load at 0x0000_0022 with mem_data 0x9ABC1234:
  - signed returns 0xFFFF9ABC.
  - at 0x20 returns 0x00001234.
- Errors (no memory access, cen/wmask stay 0, rsp_valid at T+1, rsp_err 1, rdata 0):
  - Word at 0x0000_0006.
  - Half at 0x0000_0001.
  - size 11.
  - Address 0x0001_0000 with ADDR_BITS=16.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load.
  - rsp_valid/rsp_rdata stay stable and req_ready stays 0.
  - A new req_valid is ignored until one cycle after rsp_ready=1.
- Reset during ISSUE of a word store: reset low asynchronously mid-cycle.
  - mem_cen and mem_wmask go 0 without waiting for a clock edge.
  - After release: IDLE, req_ready 1, rsp_valid 0.
